// File: rtl/mpy_arb2.sv
// Two-requester arbiter/pipeline front end for a combinational 16x16 / dual 8x8 multiplier.
// Define MPY_ARB_RR_EN for round-robin arbitration; otherwise r0 has fixed priority.
module mpy_arb2 (
  input  logic        clk,
  input  logic        RST,
  input  logic        r0_valid,
  output logic        r0_ready,
  input  logic [15:0] r0_a,
  input  logic [15:0] r0_b,
  input  logic        r0_asgn,
  input  logic        r0_bsgn,
  input  logic        r0_mode8,
  output logic        r0_rvalid,
  input  logic        r0_rready,
  output logic [31:0] r0_result,
  input  logic        r1_valid,
  output logic        r1_ready,
  input  logic [15:0] r1_a,
  input  logic [15:0] r1_b,
  input  logic        r1_asgn,
  input  logic        r1_bsgn,
  input  logic        r1_mode8,
  output logic        r1_rvalid,
  input  logic        r1_rready,
  output logic [31:0] r1_result,
  output logic [15:0] m_a,
  output logic [15:0] m_b,
  output logic        m_asgnd,
  output logic        m_bsgnd,
  output logic        m_mode8,
  output logic        m_fsel,
  output logic        m_gsel,
  output logic        m_hsel,
  output logic        m_jksel,
  input  logic [31:0] m_o16,
  input  logic [15:0] m_oh,
  input  logic [15:0] m_ol,
  output logic        busy
);

  localparam int unsigned OPW = 16;
  localparam int unsigned RW  = 32;

  logic [OPW-1:0] m_a_q, m_a_d, m_b_q, m_b_d;
  logic           m_asgnd_q, m_asgnd_d, m_bsgnd_q, m_bsgnd_d, m_mode8_q, m_mode8_d;
  logic           s1_vld_q, s1_vld_d, s1_id_q, s1_id_d;
  logic [1:0]     full_q, full_d;
  logic [RW-1:0]  slot0_q, slot0_d, slot1_q, slot1_d;
  logic [1:0]     credit, cand, grant;
  logic [RW-1:0]  mpy_res;
`ifdef MPY_ARB_RR_EN
  logic           rr_ptr_q, rr_ptr_d;
`endif

  // A requester may issue only if it has nothing in the issue stage and its slot will be free.
  always_comb begin
    credit[0] = ~(s1_vld_q & ~s1_id_q) & (~full_q[0] | r0_rready);
    credit[1] = ~(s1_vld_q &  s1_id_q) & (~full_q[1] | r1_rready);
    cand      = {r1_valid & credit[1], r0_valid & credit[0]} & {2{~RST}};
`ifdef MPY_ARB_RR_EN
    if (&cand) grant = rr_ptr_q ? 2'b10 : 2'b01;
    else       grant = cand;
`else
    grant = {cand[1] & ~cand[0], cand[0]};
`endif
  end

  // Issue stage: operands only move when a request is accepted, so the multiplier stays quiet on idle.
  always_comb begin
    m_a_d     = m_a_q;
    m_b_d     = m_b_q;
    m_asgnd_d = m_asgnd_q;
    m_bsgnd_d = m_bsgnd_q;
    m_mode8_d = m_mode8_q;
    s1_vld_d  = |grant;
    s1_id_d   = grant[1];
    if (grant[0]) begin
      m_a_d     = r0_a;
      m_b_d     = r0_b;
      m_asgnd_d = r0_asgn;
      m_bsgnd_d = r0_bsgn;
      m_mode8_d = r0_mode8;
    end else if (grant[1]) begin
      m_a_d     = r1_a;
      m_b_d     = r1_b;
      m_asgnd_d = r1_asgn;
      m_bsgnd_d = r1_bsgn;
      m_mode8_d = r1_mode8;
    end
  end

  // Result slots: a load on the same edge as a drain keeps the slot full.
  always_comb begin
    mpy_res   = m_mode8_q ? {m_oh, m_ol} : m_o16;
    slot0_d   = slot0_q;
    slot1_d   = slot1_q;
    full_d[0] = full_q[0] & ~r0_rready;
    full_d[1] = full_q[1] & ~r1_rready;
    if (s1_vld_q && !s1_id_q) begin
      slot0_d   = mpy_res;
      full_d[0] = 1'b1;
    end
    if (s1_vld_q && s1_id_q) begin
      slot1_d   = mpy_res;
      full_d[1] = 1'b1;
    end
  end

`ifdef MPY_ARB_RR_EN
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant[0])      rr_ptr_d = 1'b1;
    else if (grant[1]) rr_ptr_d = 1'b0;
  end
`endif

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      m_a_q     <= '0;
      m_b_q     <= '0;
      m_asgnd_q <= 1'b0;
      m_bsgnd_q <= 1'b0;
      m_mode8_q <= 1'b0;
      s1_vld_q  <= 1'b0;
      s1_id_q   <= 1'b0;
      full_q    <= '0;
      slot0_q   <= '0;
      slot1_q   <= '0;
`ifdef MPY_ARB_RR_EN
      rr_ptr_q  <= 1'b0;
`endif
    end else begin
      m_a_q     <= m_a_d;
      m_b_q     <= m_b_d;
      m_asgnd_q <= m_asgnd_d;
      m_bsgnd_q <= m_bsgnd_d;
      m_mode8_q <= m_mode8_d;
      s1_vld_q  <= s1_vld_d;
      s1_id_q   <= s1_id_d;
      full_q    <= full_d;
      slot0_q   <= slot0_d;
      slot1_q   <= slot1_d;
`ifdef MPY_ARB_RR_EN
      rr_ptr_q  <= rr_ptr_d;
`endif
    end
  end

  assign r0_ready  = grant[0];
  assign r1_ready  = grant[1];
  assign r0_rvalid = full_q[0];
  assign r1_rvalid = full_q[1];
  assign r0_result = slot0_q;
  assign r1_result = slot1_q;
  assign m_a       = m_a_q;
  assign m_b       = m_b_q;
  assign m_asgnd   = m_asgnd_q;
  assign m_bsgnd   = m_bsgnd_q;
  assign m_mode8   = m_mode8_q;
  assign m_fsel    = 1'b0;
  assign m_gsel    = 1'b0;
  assign m_hsel    = 1'b0;
  assign m_jksel   = 1'b0;
  assign busy      = s1_vld_q | full_q[0] | full_q[1];

endmodule

// File: tb/tb_mpy_arb2.sv
// Bench for mpy_arb2 with a behavioural combinational multiplier and a per-requester scoreboard.
module tb_mpy_arb2;

  logic        clk, RST;
  logic        r0_valid, r0_ready, r0_asgn, r0_bsgn, r0_mode8, r0_rvalid, r0_rready;
  logic        r1_valid, r1_ready, r1_asgn, r1_bsgn, r1_mode8, r1_rvalid, r1_rready;
  logic [15:0] r0_a, r0_b, r1_a, r1_b, m_a, m_b, m_oh, m_ol;
  logic [31:0] r0_result, r1_result, m_o16;
  logic        m_asgnd, m_bsgnd, m_mode8, m_fsel, m_gsel, m_hsel, m_jksel, busy;

  int total = 0;
  int bad   = 0;
  logic [31:0] q0[$];
  logic [31:0] q1[$];

  mpy_arb2 dut (
    .clk(clk), .RST(RST),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_a(r0_a), .r0_b(r0_b),
    .r0_asgn(r0_asgn), .r0_bsgn(r0_bsgn), .r0_mode8(r0_mode8),
    .r0_rvalid(r0_rvalid), .r0_rready(r0_rready), .r0_result(r0_result),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_a(r1_a), .r1_b(r1_b),
    .r1_asgn(r1_asgn), .r1_bsgn(r1_bsgn), .r1_mode8(r1_mode8),
    .r1_rvalid(r1_rvalid), .r1_rready(r1_rready), .r1_result(r1_result),
    .m_a(m_a), .m_b(m_b), .m_asgnd(m_asgnd), .m_bsgnd(m_bsgnd), .m_mode8(m_mode8),
    .m_fsel(m_fsel), .m_gsel(m_gsel), .m_hsel(m_hsel), .m_jksel(m_jksel),
    .m_o16(m_o16), .m_oh(m_oh), .m_ol(m_ol), .busy(busy)
  );

  // Behavioural multiplier: sign-extend each operand by one bit, multiply as signed.
  logic signed [16:0] ax, bx;
  logic signed [8:0]  ahx, alx, bhx, blx;
  logic signed [33:0] p16;
  logic signed [17:0] ph, pl;
  assign ax    = {m_asgnd & m_a[15], m_a};
  assign bx    = {m_bsgnd & m_b[15], m_b};
  assign ahx   = {m_asgnd & m_a[15], m_a[15:8]};
  assign alx   = {m_asgnd & m_a[7],  m_a[7:0]};
  assign bhx   = {m_bsgnd & m_b[15], m_b[15:8]};
  assign blx   = {m_bsgnd & m_b[7],  m_b[7:0]};
  assign p16   = ax * bx;
  assign ph    = ahx * bhx;
  assign pl    = alx * blx;
  assign m_o16 = p16[31:0];
  assign m_oh  = ph[15:0];
  assign m_ol  = pl[15:0];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] exp_prod(input logic [15:0] a, input logic [15:0] b,
                                           input logic as_, input logic bs, input logic m8);
    longint x, y, p, ph_l, pl_l;
    logic [7:0] ah, al, bh, bl;
    ah = a[15:8]; al = a[7:0]; bh = b[15:8]; bl = b[7:0];
    if (!m8) begin
      x = as_ ? longint'($signed(a)) : longint'(a);
      y = bs  ? longint'($signed(b)) : longint'(b);
      p = x * y;
      return 32'(p);
    end
    ph_l = (as_ ? longint'($signed(ah)) : longint'(ah)) * (bs ? longint'($signed(bh)) : longint'(bh));
    pl_l = (as_ ? longint'($signed(al)) : longint'(al)) * (bs ? longint'($signed(bl)) : longint'(bl));
    return {16'(ph_l), 16'(pl_l)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic drive(input bit id, input logic [15:0] a, input logic [15:0] b,
                       input logic as_, input logic bs, input logic m8);
    if (!id) begin
      r0_valid = 1'b1; r0_a = a; r0_b = b; r0_asgn = as_; r0_bsgn = bs; r0_mode8 = m8;
    end else begin
      r1_valid = 1'b1; r1_a = a; r1_b = b; r1_asgn = as_; r1_bsgn = bs; r1_mode8 = m8;
    end
  endtask

  // Scoreboard: push at accept, pop at result handshake; reset discards everything in flight.
  always @(negedge clk) begin
    if (RST) begin
      q0.delete();
      q1.delete();
    end else begin
      if (r0_valid && r0_ready) q0.push_back(exp_prod(r0_a, r0_b, r0_asgn, r0_bsgn, r0_mode8));
      if (r1_valid && r1_ready) q1.push_back(exp_prod(r1_a, r1_b, r1_asgn, r1_bsgn, r1_mode8));
      if (r0_rvalid && r0_rready) begin
        if (q0.size() == 0) chk("r0_spurious_result", 32'd1, 32'd0);
        else                chk("r0_sb_result", r0_result, q0.pop_front());
      end
      if (r1_rvalid && r1_rready) begin
        if (q1.size() == 0) chk("r1_spurious_result", 32'd1, 32'd0);
        else                chk("r1_sb_result", r1_result, q1.pop_front());
      end
    end
  end

  // One isolated transaction: ready, 2-cycle latency to rvalid, result, drain, idle.
  task automatic run_single(input bit id, input logic [15:0] a, input logic [15:0] b,
                            input logic as_, input logic bs, input logic m8,
                            input logic [31:0] expv);
    drive(id, a, b, as_, bs, m8);
    smp();
    chk("single_ready", 32'(id ? r1_ready : r0_ready), 32'd1);
    nxt();
    r0_valid = 1'b0; r1_valid = 1'b0;
    smp();
    chk("single_rvalid_early", 32'(id ? r1_rvalid : r0_rvalid), 32'd0);
    chk("single_busy", 32'(busy), 32'd1);
    chk("single_m_a", 32'(m_a), 32'(a));
    nxt();
    smp();
    chk("single_rvalid", 32'(id ? r1_rvalid : r0_rvalid), 32'd1);
    chk("single_result", id ? r1_result : r0_result, expv);
    nxt();
    smp();
    chk("single_rvalid_drained", 32'(id ? r1_rvalid : r0_rvalid), 32'd0);
    chk("single_busy_idle", 32'(busy), 32'd0);
    chk("single_m_a_hold", 32'(m_a), 32'(a));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_x;
    logic [31:0] exp_y;
    RST = 1'b1;
    r0_valid = 1'b1; r0_a = 16'h1234; r0_b = 16'h5678; r0_asgn = 1'b0; r0_bsgn = 1'b0; r0_mode8 = 1'b0;
    r1_valid = 1'b1; r1_a = 16'h1111; r1_b = 16'h2222; r1_asgn = 1'b0; r1_bsgn = 1'b0; r1_mode8 = 1'b0;
    r0_rready = 1'b1; r1_rready = 1'b1;

    // Reset state with requests pending
    smp();
    chk("rst_r0_ready", 32'(r0_ready), 32'd0);
    chk("rst_r1_ready", 32'(r1_ready), 32'd0);
    chk("rst_rvalid", 32'({r0_rvalid, r1_rvalid}), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_m_ab", {m_a, m_b}, 32'd0);
    chk("rst_m_flags", 32'({m_asgnd, m_bsgnd, m_mode8}), 32'd0);
    chk("rst_m_sels", 32'({m_fsel, m_gsel, m_hsel, m_jksel}), 32'd0);
    chk("rst_results", r0_result | r1_result, 32'd0);
    nxt();
    r0_valid = 1'b0; r1_valid = 1'b0;

    // First edge after release already grants
    nxt();
    RST = 1'b0;
    run_single(1'b0, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b0, 32'hFFFE0001);
    nxt();
    run_single(1'b1, 16'hFFFF, 16'h0002, 1'b1, 1'b1, 1'b0, 32'hFFFFFFFE);
    nxt();
    run_single(1'b0, 16'h0302, 16'h0504, 1'b0, 1'b0, 1'b1, 32'h000F0008);
    nxt();
    run_single(1'b1, 16'hFF02, 16'h0304, 1'b1, 1'b1, 1'b1, 32'hFFFD0008);
    chk("sel_tied", 32'({m_fsel, m_gsel, m_hsel, m_jksel}), 32'd0);

    // Both requesters continuously valid: accepts alternate r0, r1, one per cycle
    nxt();
    drive(1'b0, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    drive(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    for (int i = 0; i < 12; i++) begin
      smp();
      chk("alt_r0_ready", 32'(r0_ready), 32'(i % 2 == 0));
      chk("alt_r1_ready", 32'(r1_ready), 32'(i % 2 == 1));
      nxt();
      drive(1'b0, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      drive(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    end
    r0_valid = 1'b0; r1_valid = 1'b0;
    repeat (4) nxt();
    smp();
    chk("alt_drained_busy", 32'(busy), 32'd0);
    chk("alt_sb_empty", 32'(q0.size() + q1.size()), 32'd0);

    // Backpressure on r0: slot held, ready blocked, then one handshake releases it
    nxt();
    r0_rready = 1'b0;
    drive(1'b0, 16'h8001, 16'h7FFF, 1'b1, 1'b0, 1'b0);
    exp_x = exp_prod(16'h8001, 16'h7FFF, 1'b1, 1'b0, 1'b0);
    exp_y = exp_prod(16'hA5C3, 16'h3C5A, 1'b1, 1'b1, 1'b1);
    smp();
    chk("bp_ready_first", 32'(r0_ready), 32'd1);
    nxt();
    drive(1'b0, 16'hA5C3, 16'h3C5A, 1'b1, 1'b1, 1'b1);
    smp();
    chk("bp_ready_inflight", 32'(r0_ready), 32'd0);
    nxt();
    smp();
    chk("bp_rvalid", 32'(r0_rvalid), 32'd1);
    chk("bp_result", r0_result, exp_x);
    for (int i = 0; i < 10; i++) begin
      nxt();
      smp();
      chk("bp_hold_ready", 32'(r0_ready), 32'd0);
      chk("bp_hold_rvalid", 32'(r0_rvalid), 32'd1);
      chk("bp_hold_result", r0_result, exp_x);
    end
    chk("bp_m_a_hold", 32'(m_a), 32'h8001);
    nxt();
    r0_rready = 1'b1;
    smp();
    chk("bp_ready_release", 32'(r0_ready), 32'd1);
    nxt();
    r0_valid = 1'b0;
    smp();
    chk("bp_rvalid_gap", 32'(r0_rvalid), 32'd0);
    nxt();
    smp();
    chk("bp_rvalid_y", 32'(r0_rvalid), 32'd1);
    chk("bp_result_y", r0_result, exp_y);
    nxt();
    smp();
    chk("bp_idle", 32'({r0_rvalid, busy}), 32'd0);

    // Reset pulsed one cycle after accept discards the in-flight result
    nxt();
    drive(1'b0, 16'h00FF, 16'h00FF, 1'b0, 1'b0, 1'b0);
    smp();
    chk("rmid_ready", 32'(r0_ready), 32'd1);
    nxt();
    r0_valid = 1'b0;
    RST = 1'b1;
    smp();
    chk("rmid_busy", 32'(busy), 32'd0);
    chk("rmid_m_a", 32'(m_a), 32'd0);
    chk("rmid_rvalid", 32'({r0_rvalid, r1_rvalid}), 32'd0);
    nxt();
    RST = 1'b0;
    for (int i = 0; i < 4; i++) begin
      smp();
      chk("rpost_rvalid", 32'({r0_rvalid, r1_rvalid}), 32'd0);
      chk("rpost_busy", 32'(busy), 32'd0);
      chk("rpost_result", r0_result, 32'd0);
      nxt();
    end
    run_single(1'b1, 16'h0010, 16'h0020, 1'b0, 1'b0, 1'b0, 32'h00000200);

    nxt();
    smp();
    chk("final_sb_empty", 32'(q0.size() + q1.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mpy_arb2.md
MPY_ARB2 -- requirements
Module: mpy_arb2

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock; one clock, all state in this domain.
REQ-002 SHALL have: RST  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have per requester n in {0,1}: rn_valid in 1, rn_ready out 1, rn_a in 16, rn_b in 16, rn_asgn in 1 (A signed), rn_bsgn in 1 (B signed), rn_mode8 in 1 (dual 8x8 op).
REQ-004 SHALL have per requester: rn_rvalid out 1, rn_rready in 1, rn_result out 32 (product).
REQ-005 SHALL have multiplier-side outputs: m_a 16, m_b 16, m_asgnd 1, m_bsgnd 1, m_mode8 1, m_fsel/m_gsel/m_hsel/m_jksel 1 each.
REQ-006 SHALL have multiplier-side inputs: m_o16 32 (16x16 product), m_oh 16 (high-byte 8x8 product), m_ol 16 (low-byte 8x8 product).
REQ-007 SHALL have status output busy out 1 = issue stage valid OR any result slot full.

Function
REQ-008 SHALL tie m_fsel, m_gsel, m_hsel, m_jksel to 0 (multiplier used fully combinational; arbiter provides all pipeline registers).
REQ-009 SHALL hold, per requester, one-bit credit_n = NOT(s1_vld AND s1_id==n) AND (NOT full_n OR rn_rready).
REQ-010 SHALL drive rn_ready = grant_n, where candidate_n = rn_valid AND credit_n; grant is combinational, at most one requester per cycle.
REQ-011 SHALL grant the sole candidate when only one exists; with two candidates, grant per REQ-030/REQ-031.
REQ-012 SHALL, on accept edge E0 (rn_valid AND rn_ready), register operands into the issue stage: m_a, m_b, m_asgnd, m_bsgnd, m_mode8, s1_id=n, s1_vld=1; s1_vld=0 when no grant.
REQ-013 SHALL, at edge E1 following E0, load slot s1_id with {m_oh,m_ol} when s1_mode8=1, else m_o16, and set full_(s1_id).
REQ-014 SHALL drive rn_rvalid = full_n and rn_result = slot_n; latency accept-edge to rvalid = 2 cycles.
REQ-015 SHALL clear full_n on edge where rn_rvalid AND rn_rready, unless the same edge loads slot n (load wins, full_n stays 1).
REQ-016 SHALL keep rn_result stable while rn_rvalid=1 and rn_rready=0.
REQ-017 SHALL hold m_a/m_b/signs/m_mode8 at last issued values when s1_vld=0 (no toggling on idle).
REQ-018 SHALL sustain one issue per cycle when both requesters alternate; single requester sustains one issue per 2 cycles (credit rule).
REQ-019 SHALL ignore rn_a/rn_b/sign/mode inputs when not accepted.
REQ-020 SHALL never lose or duplicate a result: each accept yields exactly one rvalid/rready handshake on the same requester.

Reset
REQ-021 SHALL, while RST=1, force s1_vld=0, full_0=full_1=0, rn_ready=0, rn_rvalid=0, busy=0, rr_ptr=0, m_a=m_b=0, m_asgnd=m_bsgnd=m_mode8=0, slots=0.
REQ-022 SHALL discard any in-flight or buffered result on reset mid-operation; no rvalid after release until a new accept.
REQ-023 SHALL allow grants on the first clk edge after RST deasserts.

Configuration
REQ-030 SHALL, with MPY_ARB_RR_EN defined, arbitrate round-robin: rr_ptr names the preferred requester; after a grant to n, rr_ptr = 1-n; reset value prefers r0.
REQ-031 SHALL, without MPY_ARB_RR_EN, use fixed priority r0 over r1; rr_ptr logic absent.

Verification
REQ-040 SHALL check: r0 16x16 unsigned A=0xFFFF B=0xFFFF -> r0_result=0xFFFE0001, r0_rvalid 2 cycles after accept.
REQ-041 SHALL check: r1 signed A=0xFFFF B=0x0002 asgn=bsgn=1 -> r1_result=0xFFFFFFFE.
REQ-042 SHALL check: r0 mode8 unsigned A=0x0302 B=0x0504 -> r0_result=0x000F0008.
REQ-043 SHALL check: both valid continuously, rready=1, RR_EN defined -> grants alternate r0,r1,r0,r1, one accept per cycle; undefined -> r0 accepts every 2nd cycle, r1 only in gaps.
REQ-044 SHALL check: r0_rready=0 with slot full -> r0_ready=0, r0_result held 10 cycles; rready=1 -> one handshake, then r0_ready returns.
REQ-045 SHALL check: RST pulsed 1 cycle after accept -> no rvalid afterwards, busy=0, outputs at reset values.
